jtframe_sdram_share2: RTL and testbench

//  Two-master arbiter for one SDRAM controller bank port. Each master is a slot

---
 rtl/jtframe_sdram_share2.sv | 163 ++++++++++++++++
 tb/tb_jtframe_sdram_share2.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_share2.sv
// Two-master arbiter in front of one SDRAM controller bank port.
// Master A has priority; a starvation counter makes sure B is eventually served.
//
// state   | meaning
// IDLE    | no transfer; arbitrate and latch the winner's request
// REQ     | request on the bus, waiting for sdram_ack
// WAIT    | request accepted, waiting for data_rdy
module jtframe_sdram_share2 #(
  parameter int SDRAMW = 22,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_rd,
  input  logic              a_wr,
  input  logic [SDRAMW-1:0] a_addr,
  input  logic [15:0]       a_din,
  input  logic [1:0]        a_wrmask,
  output logic              a_ack,
  output logic              a_rdy,
  output logic              a_dst,

  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [SDRAMW-1:0] b_addr,
  input  logic [15:0]       b_din,
  input  logic [1:0]        b_wrmask,
  output logic              b_ack,
  output logic              b_rdy,
  output logic              b_dst,

  output logic              sdram_rd,
  output logic              sdram_wr,
  output logic [SDRAMW-1:0] sdram_addr,
  output logic [15:0]       data_write,
  output logic [1:0]        sdram_wrmask,
  input  logic              sdram_ack,
  input  logic              data_rdy,
  input  logic              data_dst
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [3:0] STARVE_L = 4'(STARVE);

  logic [1:0]        st;
  logic              grant_a;
  logic              grant_b;
  logic [3:0]        starve_cnt;

  logic              req_a;
  logic              req_b;
  logic              pick_a;
  logic              pick_b;
  logic              win_rd;
  logic              win_wr;
  logic [SDRAMW-1:0] win_addr;
  logic [15:0]       win_din;
  logic [1:0]        win_mask;
  logic              in_req;
  logic              in_wait;
  logic              done;

  assign req_a  = a_rd | a_wr;
  assign req_b  = b_rd | b_wr;
  assign pick_b = req_b && (!req_a || starve_cnt == STARVE_L);
  assign pick_a = req_a && !pick_b;

  always_comb begin
    win_rd   = 1'b0;
    win_wr   = 1'b0;
    win_addr = a_addr;
    win_din  = a_din;
    win_mask = a_wrmask;
    if (pick_b) begin
      win_rd   = b_rd;
      win_wr   = b_wr;
      win_addr = b_addr;
      win_din  = b_din;
      win_mask = b_wrmask;
    end else if (pick_a) begin
      win_rd   = a_rd;
      win_wr   = a_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      grant_a      <= 1'b0;
      grant_b      <= 1'b0;
      starve_cnt   <= 4'd0;
      sdram_rd     <= 1'b0;
      sdram_wr     <= 1'b0;
      sdram_addr   <= '0;
      data_write   <= 16'd0;
      sdram_wrmask <= 2'b11;
    end else begin
      case (st)
        ST_IDLE: begin
          if (pick_a || pick_b) begin
            grant_a      <= pick_a;
            grant_b      <= pick_b;
            sdram_addr   <= win_addr;
            data_write   <= win_din;
            // write wins when a master raises both rd and wr
            sdram_wr     <= win_wr;
            sdram_rd     <= win_rd & ~win_wr;
            sdram_wrmask <= win_wr ? win_mask : 2'b11;
            st           <= ST_REQ;
            if (pick_a && req_b)
              starve_cnt <= (starve_cnt == STARVE_L) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= 4'd0;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            sdram_wr <= 1'b0;
            if (data_rdy) begin
              grant_a <= 1'b0;
              grant_b <= 1'b0;
              st      <= ST_IDLE;
            end else begin
              st      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            st      <= ST_IDLE;
          end
        end
        default: begin
          grant_a  <= 1'b0;
          grant_b  <= 1'b0;
          sdram_rd <= 1'b0;
          sdram_wr <= 1'b0;
          st       <= ST_IDLE;
        end
      endcase
    end
  end

  // completion can coincide with the ack cycle when the controller is fast
  assign in_req  = (st == ST_REQ);
  assign in_wait = (st == ST_WAIT);
  assign done    = (in_req & sdram_ack & data_rdy) | (in_wait & data_rdy);

  assign a_ack = in_req & sdram_ack & grant_a;
  assign b_ack = in_req & sdram_ack & grant_b;
  assign a_rdy = done & grant_a;
  assign b_rdy = done & grant_b;
  assign a_dst = in_wait & data_dst & grant_a;
  assign b_dst = in_wait & data_dst & grant_b;

endmodule

// File: tb/tb_jtframe_sdram_share2.sv
// Directed bench for jtframe_sdram_share2: expected acks/rdys go into queues,
// a negedge monitor pops and compares whenever the DUT pulses them.
module tb_jtframe_sdram_share2;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [21:0] a_addr, b_addr;
  logic [15:0] a_din, b_din;
  logic [1:0]  a_wrmask, b_wrmask;
  logic        a_ack, a_rdy, a_dst, b_ack, b_rdy, b_dst;
  logic        sdram_rd, sdram_wr;
  logic [21:0] sdram_addr;
  logic [15:0] data_write;
  logic [1:0]  sdram_wrmask;
  logic        sdram_ack, data_rdy, data_dst;

  typedef struct {
    logic        is_b;
    logic        wr;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  mask;
  } exp_t;

  exp_t ack_q[$];
  logic rdy_q[$];
  exp_t mon_e;
  logic mon_m;
  int   total = 0;
  int   bad = 0;
  int   a_dst_cnt = 0;
  int   b_dst_cnt = 0;

  always #5 clk = ~clk;

  jtframe_sdram_share2 #(.SDRAMW(22), .STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_wrmask(a_wrmask),
    .a_ack(a_ack), .a_rdy(a_rdy), .a_dst(a_dst),
    .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_wrmask(b_wrmask),
    .b_ack(b_ack), .b_rdy(b_rdy), .b_dst(b_dst),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr(sdram_addr),
    .data_write(data_write), .sdram_wrmask(sdram_wrmask),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_dst(data_dst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_b, input logic wr, input logic [21:0] addr,
                      input logic [15:0] din, input logic [1:0] mask, input logic with_rdy);
    exp_t e;
    e.is_b = is_b; e.wr = wr; e.addr = addr; e.din = din; e.mask = mask;
    ack_q.push_back(e);
    if (with_rdy) rdy_q.push_back(is_b);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!(sdram_rd | sdram_wr) && n < 20) begin
      cyc();
      n++;
    end
    if (!(sdram_rd | sdram_wr)) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: no sdram_rd/sdram_wr within 20 cycles");
    end
  endtask

  // controller model: ack after ack_wait cycles, data_rdy rdy_wait cycles later
  task automatic serve(input int ack_wait, input int rdy_wait, input logic drop_a, input logic drop_b);
    cyc();
    wait_issue();
    repeat (ack_wait) cyc();
    sdram_ack = 1'b1;
    cyc();
    sdram_ack = 1'b0;
    if (drop_a) begin a_rd = 1'b0; a_wr = 1'b0; end
    if (drop_b) begin b_rd = 1'b0; b_wr = 1'b0; end
    repeat (rdy_wait) cyc();
    data_rdy = 1'b1;
    data_dst = 1'b1;
    cyc();
    data_rdy = 1'b0;
    data_dst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_dst) a_dst_cnt++;
      if (b_dst) b_dst_cnt++;
      if (a_ack | b_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", {30'd0, a_ack, b_ack}, 32'd0);
        else begin
          mon_e = ack_q.pop_front();
          chk("ack_master", {30'd0, a_ack, b_ack}, mon_e.is_b ? 32'd1 : 32'd2);
          chk("ack_sdram_wr", {31'd0, sdram_wr}, {31'd0, mon_e.wr});
          chk("ack_sdram_rd", {31'd0, sdram_rd}, {31'd0, ~mon_e.wr});
          chk("ack_addr", {10'd0, sdram_addr}, {10'd0, mon_e.addr});
          chk("ack_data_write", {16'd0, data_write}, {16'd0, mon_e.din});
          chk("ack_wrmask", {30'd0, sdram_wrmask}, {30'd0, mon_e.mask});
        end
      end
      if (a_rdy | b_rdy) begin
        if (rdy_q.size() == 0) chk("unexpected_rdy", {30'd0, a_rdy, b_rdy}, 32'd0);
        else begin
          mon_m = rdy_q.pop_front();
          chk("rdy_master", {30'd0, a_rdy, b_rdy}, mon_m ? 32'd1 : 32'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_addr = '0; a_din = '0; a_wrmask = 2'b11;
    b_rd = 0; b_wr = 0; b_addr = '0; b_din = '0; b_wrmask = 2'b11;
    sdram_ack = 0; data_rdy = 0; data_dst = 0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sdram_rd", {31'd0, sdram_rd}, 32'd0);
    chk("rst_sdram_wr", {31'd0, sdram_wr}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_data_write", {16'd0, data_write}, 32'd0);
    chk("rst_wrmask", {30'd0, sdram_wrmask}, 32'd3);

    // 1: A read alone, mask forced to 11
    cyc();
    a_rd = 1; a_addr = 22'h000100; a_din = 16'hBEEF; a_wrmask = 2'b00;
    push(1'b0, 1'b0, 22'h000100, 16'hBEEF, 2'b11, 1'b1);
    @(negedge clk);
    chk("t1_rd_not_yet", {31'd0, sdram_rd}, 32'd0);
    @(negedge clk);
    chk("t1_rd_next_cycle", {31'd0, sdram_rd}, 32'd1);
    serve(1, 2, 1'b1, 1'b0);
    chk("t1_a_dst_cnt", a_dst_cnt, 32'd1);

    // 2: A write
    cyc();
    a_wr = 1; a_addr = 22'h000040; a_din = 16'h1234; a_wrmask = 2'b10;
    push(1'b0, 1'b1, 22'h000040, 16'h1234, 2'b10, 1'b1);
    serve(0, 1, 1'b1, 1'b0);

    // 3: both request continuously, B every fifth grant
    a_rd = 1; a_addr = 22'h000200; a_din = 16'h1111; a_wrmask = 2'b00;
    b_rd = 1; b_addr = 22'h000300; b_din = 16'h2222; b_wrmask = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push(1'b1, 1'b0, 22'h000300, 16'h2222, 2'b11, 1'b1);
      else                  push(1'b0, 1'b0, 22'h000200, 16'h1111, 2'b11, 1'b1);
    end
    for (int i = 0; i < 10; i++) serve(0, 0, i == 9, i == 9);

    // 4: stray controller strobes in IDLE
    cyc();
    data_rdy = 1; data_dst = 1; sdram_ack = 1;
    @(negedge clk);
    chk("t4_a_rdy", {31'd0, a_rdy}, 32'd0);
    chk("t4_b_rdy", {31'd0, b_rdy}, 32'd0);
    chk("t4_a_ack", {31'd0, a_ack}, 32'd0);
    chk("t4_a_dst", {31'd0, a_dst}, 32'd0);
    cyc();
    data_rdy = 0; data_dst = 0; sdram_ack = 0;
    @(negedge clk);
    chk("t4_sdram_rd", {31'd0, sdram_rd}, 32'd0);
    chk("t4_sdram_wr", {31'd0, sdram_wr}, 32'd0);

    // 5: reset while B is in WAIT, then a late data_rdy
    cyc();
    b_wr = 1; b_addr = 22'h3FFFFF; b_din = 16'hA5A5; b_wrmask = 2'b01;
    push(1'b1, 1'b1, 22'h3FFFFF, 16'hA5A5, 2'b01, 1'b0);
    cyc();
    wait_issue();
    sdram_ack = 1;
    cyc();
    sdram_ack = 0; b_wr = 0;
    rst = 1;
    cyc();
    rst = 0;
    data_rdy = 1; data_dst = 1;
    @(negedge clk);
    chk("t5_b_rdy", {31'd0, b_rdy}, 32'd0);
    chk("t5_b_dst", {31'd0, b_dst}, 32'd0);
    chk("t5_sdram_wr", {31'd0, sdram_wr}, 32'd0);
    chk("t5_addr", {10'd0, sdram_addr}, 32'd0);
    chk("t5_data_write", {16'd0, data_write}, 32'd0);
    chk("t5_wrmask", {30'd0, sdram_wrmask}, 32'd3);
    cyc();
    data_rdy = 0; data_dst = 0;

    // 6: B write with ack and data_rdy together, A waiting behind it
    b_wr = 1; b_addr = 22'h000055; b_din = 16'h7777; b_wrmask = 2'b00;
    push(1'b1, 1'b1, 22'h000055, 16'h7777, 2'b00, 1'b1);
    cyc();
    wait_issue();
    a_rd = 1; a_addr = 22'h000010; a_din = 16'h0F0F;
    push(1'b0, 1'b0, 22'h000010, 16'h0F0F, 2'b11, 1'b1);
    sdram_ack = 1; data_rdy = 1; data_dst = 1;
    @(negedge clk);
    chk("t6_a_ack", {31'd0, a_ack}, 32'd0);
    chk("t6_b_dst", {31'd0, b_dst}, 32'd0);
    cyc();
    sdram_ack = 0; data_rdy = 0; data_dst = 0; b_wr = 0;
    @(negedge clk);
    chk("t6_bubble", {31'd0, sdram_rd}, 32'd0);
    @(negedge clk);
    chk("t6_a_issued", {31'd0, sdram_rd}, 32'd1);
    serve(0, 0, 1'b1, 1'b0);

    repeat (3) cyc();
    chk("ack_q_left", ack_q.size(), 32'd0);
    chk("rdy_q_left", rdy_q.size(), 32'd0);
    chk("a_dst_total", a_dst_cnt, 32'd11);
    chk("b_dst_total", b_dst_cnt, 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
